// File: rtl/phase_sequence_monitor_pkg.sv
// Shared definitions for the phase sequence monitor: FSM encoding, error codes
// and the one-hot phase constants of the six-phase ring.
package phase_sequence_monitor_pkg;

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_LOCKED = 2'd1,
        ST_ERROR  = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ENC   = 2'b01;
    localparam logic [1:0] ERR_ORDER = 2'b10;

    localparam logic [2:0] PH_LAST = 3'd5;

    localparam logic [5:0] PH0 = 6'b000001;
    localparam logic [5:0] PH1 = 6'b000010;
    localparam logic [5:0] PH2 = 6'b000100;
    localparam logic [5:0] PH3 = 6'b001000;
    localparam logic [5:0] PH4 = 6'b010000;
    localparam logic [5:0] PH5 = 6'b100000;

    // Successor of a stage index around the ring.
    function automatic logic [2:0] ring_next(input logic [2:0] idx);
        return (idx == PH_LAST) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/phase_sequence_monitor_decode.sv
// Combinational one-hot to index decoder for the phase bus; legal_o is set
// only when exactly one phase line is active.
module phase_onehot_decode #(
    parameter int NUM_PH = 6
) (
    input  logic [NUM_PH-1:0] phases_i,
    output logic [2:0]        idx_o,
    output logic              legal_o
);

    logic [2:0] idx_terms [NUM_PH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PH; gi++) begin : g_term
            assign idx_terms[gi] = phases_i[gi] ? 3'(gi) : 3'd0;
        end
    endgenerate

    // OR of the per-line terms is the index whenever the input is one-hot.
    always_comb begin
        idx_o = 3'd0;
        for (int i = 0; i < NUM_PH; i++) begin
            idx_o = idx_o | idx_terms[i];
        end
    end

    assign legal_o = $onehot(phases_i);

endmodule

// File: rtl/phase_sequence_monitor.sv
// Phase sequence monitor: locks to the six-phase ring, counts instructions and
// flags encoding/order faults. Define PHASE_ERR_CAPTURE_EN to capture ErrPhases.
module phase_sequence_monitor
    import phase_sequence_monitor_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int NUM_PH = 6
) (
    input  logic              inClk,
    input  logic              Reset,
    input  logic [NUM_PH-1:0] Phases,
    input  logic              ClearErr,
    output logic [2:0]        StageIdx,
    output logic              StageValid,
    output logic              InstrDone,
    output logic              Restart,
    output logic [CNT_W-1:0]  InstrCount,
    output logic              PhaseError,
    output logic [1:0]        ErrCode,
    output logic [NUM_PH-1:0] ErrPhases
);

    state_e            state_q, state_d;
    logic [2:0]        exp_q, exp_d;
    logic [2:0]        stage_idx_q, stage_idx_d;
    logic              instr_done_d, restart_d;
    logic              instr_done_q, restart_q;
    logic              stage_valid_q;
    logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [2:0]        dec_idx;
    logic              dec_legal;

    phase_onehot_decode #(
        .NUM_PH (NUM_PH)
    ) u_decode (
        .phases_i (Phases),
        .idx_o    (dec_idx),
        .legal_o  (dec_legal)
    );

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        stage_idx_d  = stage_idx_q;
        instr_cnt_d  = instr_cnt_q;
        err_code_d   = err_code_q;
        instr_done_d = 1'b0;
        restart_d    = 1'b0;
        unique case (state_q)
            ST_UNSYNC: begin
                if (Phases == NUM_PH'(PH0)) begin
                    state_d     = ST_LOCKED;
                    stage_idx_d = 3'd0;
                    exp_d       = 3'd1;
                end
            end
            ST_LOCKED: begin
                if (!dec_legal) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_ENC;
                end else if (dec_idx == exp_q) begin
                    stage_idx_d = dec_idx;
                    exp_d       = ring_next(dec_idx);
                    if (dec_idx == PH_LAST) begin
                        instr_done_d = 1'b1;
                        instr_cnt_d  = instr_cnt_q + CNT_W'(1);
                    end
                end else if (dec_idx == 3'd0) begin
                    // Generator restarted mid-instruction: resync without counting.
                    restart_d   = 1'b1;
                    stage_idx_d = 3'd0;
                    exp_d       = 3'd1;
                end else begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_ORDER;
                end
            end
            ST_ERROR: begin
                if (ClearErr) begin
                    state_d    = ST_UNSYNC;
                    err_code_d = ERR_NONE;
                end
            end
            default: begin
                state_d = ST_UNSYNC;
            end
        endcase
    end

    always_ff @(posedge inClk or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_UNSYNC;
            exp_q         <= 3'd0;
            stage_idx_q   <= 3'd0;
            stage_valid_q <= 1'b0;
            instr_done_q  <= 1'b0;
            restart_q     <= 1'b0;
            instr_cnt_q   <= '0;
            err_code_q    <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            exp_q         <= exp_d;
            stage_idx_q   <= stage_idx_d;
            stage_valid_q <= (state_d == ST_LOCKED);
            instr_done_q  <= instr_done_d;
            restart_q     <= restart_d;
            instr_cnt_q   <= instr_cnt_d;
            err_code_q    <= err_code_d;
        end
    end

`ifdef PHASE_ERR_CAPTURE_EN
    logic [NUM_PH-1:0] err_phases_q, err_phases_d;

    // Latch only on the transition into ERROR so the culprit vector is kept.
    always_comb begin
        err_phases_d = err_phases_q;
        if (state_q == ST_LOCKED && state_d == ST_ERROR) begin
            err_phases_d = Phases;
        end else if (state_q == ST_ERROR && state_d == ST_UNSYNC) begin
            err_phases_d = '0;
        end
    end

    always_ff @(posedge inClk or posedge Reset) begin
        if (Reset) begin
            err_phases_q <= '0;
        end else begin
            err_phases_q <= err_phases_d;
        end
    end

    assign ErrPhases = err_phases_q;
`else
    assign ErrPhases = '0;
`endif

    assign StageIdx   = stage_idx_q;
    assign StageValid = stage_valid_q;
    assign InstrDone  = instr_done_q;
    assign Restart    = restart_q;
    assign InstrCount = instr_cnt_q;
    assign PhaseError = (state_q == ST_ERROR);
    assign ErrCode    = err_code_q;

endmodule
